// File: rtl/butterfly_pipe.sv
// Pipelined radix-2 complex butterfly: c = a + w*b, d = a - w*b.
// Stage S1 registers a, scale and the truncated twiddle product w*b.
// Stage S2 registers the final sums (optionally halved).
// Each stage has a valid bit. A stage advances only when its downstream stage can accept.
module butterfly_pipe #(
  parameter int BIT_WIDTH  = 32,
  parameter int DECIMAL_PT = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 recv_val,
  output logic                 recv_rdy,
  input  logic [BIT_WIDTH-1:0] aR,
  input  logic [BIT_WIDTH-1:0] aC,
  input  logic [BIT_WIDTH-1:0] bR,
  input  logic [BIT_WIDTH-1:0] bC,
  input  logic [BIT_WIDTH-1:0] wR,
  input  logic [BIT_WIDTH-1:0] wC,
  input  logic                 scale,
  output logic                 send_val,
  input  logic                 send_rdy,
  output logic [BIT_WIDTH-1:0] cR,
  output logic [BIT_WIDTH-1:0] cC,
  output logic [BIT_WIDTH-1:0] dR,
  output logic [BIT_WIDTH-1:0] dC
);

  localparam int W  = BIT_WIDTH;
  localparam int PW = 2 * BIT_WIDTH;

  // Fixed-point multiply. The full signed product is reduced by dropping the fraction,
  // which rounds toward minus infinity.
  function automatic logic [W-1:0] fx_mul(input logic [W-1:0] x, input logic [W-1:0] y);
    logic signed [PW-1:0] xs;
    logic signed [PW-1:0] ys;
    logic signed [PW-1:0] p;
    xs = $signed({{W{x[W-1]}}, x});
    ys = $signed({{W{y[W-1]}}, y});
    p  = xs * ys;
    return p[W-1+DECIMAL_PT:DECIMAL_PT];
  endfunction

  // One butterfly leg. The sum is formed one bit wider than the operands.
  // With sc=0 the result wraps to the low bits; with sc=1 it takes the upper bits,
  // which halves the sum and cannot overflow.
  function automatic logic [W-1:0] bfly_leg(input logic [W-1:0] a, input logic [W-1:0] m,
                                            input logic sub, input logic sc);
    logic [W:0] ae;
    logic [W:0] me;
    logic [W:0] s;
    logic [W-1:0] r;
    ae = {a[W-1], a};
    me = {m[W-1], m};
    if (sub) s = ae - me;
    else     s = ae + me;
    if (sc) r = s[W:1];
    else    r = s[W-1:0];
    return r;
  endfunction

  logic         v1_q, v1_d, v2_q, v2_d;
  logic         sc1_q, sc1_d;
  logic [W-1:0] ar1_q, ar1_d, ac1_q, ac1_d, mr1_q, mr1_d, mc1_q, mc1_d;
  logic [W-1:0] cr2_q, cr2_d, cc2_q, cc2_d, dr2_q, dr2_d, dc2_q, dc2_d;
  logic         rdy1, rdy2;
  logic [W-1:0] mr_s, mc_s;

  // Ready chain: a stage can take new data if it is empty or if it drains this cycle.
  always_comb begin
    rdy2 = !v2_q | send_rdy;
    rdy1 = !v1_q | rdy2;
  end

  assign recv_rdy = rdy1;
  assign send_val = v2_q;
  assign cR       = cr2_q;
  assign cC       = cc2_q;
  assign dR       = dr2_q;
  assign dC       = dc2_q;

  // Complex twiddle product w*b; each partial product is truncated before it is combined.
  always_comb begin
    mr_s = fx_mul(bR, wR) - fx_mul(bC, wC);
    mc_s = fx_mul(bR, wC) + fx_mul(bC, wR);
  end

  // S1 next state: refill when ready, otherwise hold.
  always_comb begin
    v1_d  = v1_q;
    sc1_d = sc1_q;
    ar1_d = ar1_q;
    ac1_d = ac1_q;
    mr1_d = mr1_q;
    mc1_d = mc1_q;
    if (rdy1) begin
      v1_d = recv_val;
      if (recv_val) begin
        sc1_d = scale;
        ar1_d = aR;
        ac1_d = aC;
        mr1_d = mr_s;
        mc1_d = mc_s;
      end else begin
        sc1_d = sc1_q;
      end
    end else begin
      v1_d = v1_q;
    end
  end

  // S2 next state: take the S1 result when ready, otherwise hold the outputs stable.
  always_comb begin
    v2_d  = v2_q;
    cr2_d = cr2_q;
    cc2_d = cc2_q;
    dr2_d = dr2_q;
    dc2_d = dc2_q;
    if (rdy2) begin
      v2_d = v1_q;
      if (v1_q) begin
        cr2_d = bfly_leg(ar1_q, mr1_q, 1'b0, sc1_q);
        cc2_d = bfly_leg(ac1_q, mc1_q, 1'b0, sc1_q);
        dr2_d = bfly_leg(ar1_q, mr1_q, 1'b1, sc1_q);
        dc2_d = bfly_leg(ac1_q, mc1_q, 1'b1, sc1_q);
      end else begin
        cr2_d = cr2_q;
      end
    end else begin
      v2_d = v2_q;
    end
  end

  // Pipeline registers. Reset discards in-flight work and clears the data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      sc1_q <= 1'b0;
      ar1_q <= {W{1'b0}};
      ac1_q <= {W{1'b0}};
      mr1_q <= {W{1'b0}};
      mc1_q <= {W{1'b0}};
      cr2_q <= {W{1'b0}};
      cc2_q <= {W{1'b0}};
      dr2_q <= {W{1'b0}};
      dc2_q <= {W{1'b0}};
    end else begin
      v1_q  <= v1_d;
      v2_q  <= v2_d;
      sc1_q <= sc1_d;
      ar1_q <= ar1_d;
      ac1_q <= ac1_d;
      mr1_q <= mr1_d;
      mc1_q <= mc1_d;
      cr2_q <= cr2_d;
      cc2_q <= cc2_d;
      dr2_q <= dr2_d;
      dc2_q <= dc2_d;
    end
  end

endmodule

// File: tb/tb_butterfly_pipe.sv
// Directed bench for butterfly_pipe (W=32, F=16). Inputs change on the falling edge
// and outputs are sampled away from the rising edge.
module tb_butterfly_pipe;

  localparam int          F   = 16;
  localparam logic [31:0] ONE = 32'h0001_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        recv_val, recv_rdy, scale, send_val, send_rdy;
  logic [31:0] aR, aC, bR, bC, wR, wC, cR, cC, dR, dC;
  int          nvec = 0;
  int          nerr = 0;

  butterfly_pipe #(.BIT_WIDTH(32), .DECIMAL_PT(16)) dut (
    .clk(clk), .reset(reset), .recv_val(recv_val), .recv_rdy(recv_rdy),
    .aR(aR), .aC(aC), .bR(bR), .bC(bC), .wR(wR), .wC(wC), .scale(scale),
    .send_val(send_val), .send_rdy(send_rdy),
    .cR(cR), .cC(cC), .dR(dR), .dC(dC)
  );

  always #5 clk = ~clk;

  // Reference: 64-bit products, arithmetic shift for truncation, 64-bit sums.
  function automatic logic [127:0] model(input logic [31:0] ar, input logic [31:0] ac,
      input logic [31:0] br, input logic [31:0] bc, input logic [31:0] wr,
      input logic [31:0] wc, input logic sc);
    longint prr, pcc, prc, pcr, sr, sc2, tr, tc;
    logic [31:0] mr, mc;
    prr = (longint'($signed(br)) * longint'($signed(wr))) >>> F;
    pcc = (longint'($signed(bc)) * longint'($signed(wc))) >>> F;
    prc = (longint'($signed(br)) * longint'($signed(wc))) >>> F;
    pcr = (longint'($signed(bc)) * longint'($signed(wr))) >>> F;
    mr  = prr[31:0] - pcc[31:0];
    mc  = prc[31:0] + pcr[31:0];
    sr  = longint'($signed(ar)) + longint'($signed(mr));
    sc2 = longint'($signed(ac)) + longint'($signed(mc));
    tr  = longint'($signed(ar)) - longint'($signed(mr));
    tc  = longint'($signed(ac)) - longint'($signed(mc));
    if (sc) begin
      sr = sr >>> 1; sc2 = sc2 >>> 1; tr = tr >>> 1; tc = tc >>> 1;
    end
    return {sr[31:0], sc2[31:0], tr[31:0], tc[31:0]};
  endfunction

  task automatic set_in(input logic [31:0] ar, input logic [31:0] ac, input logic [31:0] br,
      input logic [31:0] bc, input logic [31:0] wr, input logic [31:0] wc, input logic sc);
    aR = ar; aC = ac; bR = br; bC = bc; wR = wr; wC = wc; scale = sc;
  endtask

  // Sends one isolated transaction and samples the outputs one, two and three cycles later.
  task automatic run_one(input logic [31:0] ar, input logic [31:0] ac, input logic [31:0] br,
      input logic [31:0] bc, input logic [31:0] wr, input logic [31:0] wc, input logic sc,
      output logic [127:0] res, output logic v_early, output logic v_at, output logic v_after);
    @(negedge clk);
    set_in(ar, ac, br, bc, wr, wc, sc);
    recv_val = 1'b1;
    send_rdy = 1'b1;
    @(negedge clk);
    recv_val = 1'b0;
    v_early  = send_val;
    @(negedge clk);
    res  = {cR, cC, dR, dC};
    v_at = send_val;
    @(negedge clk);
    v_after = send_val;
  endtask

  task automatic test_reset;
    reset = 1'b1; recv_val = 1'b0; send_rdy = 1'b0;
    set_in(32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0);
    repeat (2) @(negedge clk);
    nvec++;
    if (send_val !== 1'b0) begin nerr++; $display("FAIL reset_send_val got %b want 0", send_val); end
    nvec++;
    if ({cR, cC, dR, dC} !== 128'd0) begin
      nerr++; $display("FAIL reset_data got %h want 0", {cR, cC, dR, dC});
    end
    reset = 1'b0;
    #1;
    nvec++;
    if (recv_rdy !== 1'b1) begin nerr++; $display("FAIL reset_recv_rdy got %b want 1", recv_rdy); end
  endtask

  task automatic test_unity;
    logic [127:0] r; logic ve, va, vf;
    run_one(32'd3, 32'd4, 32'd1, 32'd2, ONE, 32'd0, 1'b0, r, ve, va, vf);
    nvec++;
    if (ve !== 1'b0) begin nerr++; $display("FAIL unity_early_val got %b want 0", ve); end
    nvec++;
    if (va !== 1'b1) begin nerr++; $display("FAIL unity_val got %b want 1", va); end
    nvec++;
    if (r !== {32'd4, 32'd6, 32'd2, 32'd2}) begin nerr++; $display("FAIL unity_data got %h want c=(4,6) d=(2,2)", r); end
    nvec++;
    if (vf !== 1'b0) begin nerr++; $display("FAIL unity_one_cycle got %b want 0", vf); end
  endtask

  task automatic test_twiddle_j;
    logic [127:0] r; logic ve, va, vf;
    run_one(32'd3, 32'd4, 32'd1, 32'd2, 32'd0, ONE, 1'b0, r, ve, va, vf);
    nvec++;
    if (r !== {32'd1, 32'd5, 32'd5, 32'd3} || va !== 1'b1) begin
      nerr++; $display("FAIL twiddle_j got %h val %b want c=(1,5) d=(5,3)", r, va);
    end
  endtask

  task automatic test_scale;
    logic [127:0] r; logic ve, va, vf;
    run_one(32'h7FFF_FFFF, 32'd0, 32'd1, 32'd0, ONE, 32'd0, 1'b0, r, ve, va, vf);
    nvec++;
    if (r !== {32'h8000_0000, 32'd0, 32'h7FFF_FFFE, 32'd0}) begin nerr++; $display("FAIL scale0_wrap got %h", r); end
    run_one(32'h7FFF_FFFF, 32'd0, 32'd1, 32'd0, ONE, 32'd0, 1'b1, r, ve, va, vf);
    nvec++;
    if (r !== {32'h4000_0000, 32'd0, 32'h3FFF_FFFF, 32'd0}) begin nerr++; $display("FAIL scale1_big got %h", r); end
    run_one(32'd3, 32'd0, 32'd1, 32'd0, ONE, 32'd0, 1'b1, r, ve, va, vf);
    nvec++;
    if (r !== {32'd2, 32'd0, 32'd1, 32'd0}) begin nerr++; $display("FAIL scale1_small got %h want c=(2,0) d=(1,0)", r); end
  endtask

  task automatic test_trunc;
    logic [127:0] r; logic ve, va, vf;
    // (-1) * 0.5 = -0.5 rounds down to -1
    run_one(32'd0, 32'd0, 32'hFFFF_FFFF, 32'd0, 32'h0000_8000, 32'd0, 1'b0, r, ve, va, vf);
    nvec++;
    if (r !== {32'hFFFF_FFFF, 32'd0, 32'd1, 32'd0}) begin nerr++; $display("FAIL trunc_neg1 got %h", r); end
    // (-3) * 0.5 = -1.5 rounds down to -2, with a = (10, -10)
    run_one(32'd10, 32'hFFFF_FFF6, 32'hFFFF_FFFD, 32'd0, 32'h0000_8000, 32'd0, 1'b0, r, ve, va, vf);
    nvec++;
    if (r !== {32'd8, 32'hFFFF_FFF6, 32'd12, 32'hFFFF_FFF6}) begin nerr++; $display("FAIL trunc_neg3 got %h", r); end
  endtask

  task automatic test_backpressure;
    logic [31:0] ta[4];
    logic [31:0] tb_[4];
    logic [31:0] tw[4];
    logic [127:0] expv[4];
    logic [127:0] got[$];
    int cyc[$];
    int idx = 0;
    for (int k = 0; k < 4; k++) begin
      ta[k] = 32'(k * 100 + 7);
      tb_[k] = 32'(k + 1);
      tw[k] = (k % 2 == 0) ? ONE : 32'h0002_0000;
      expv[k] = model(ta[k], ta[k] + 32'd1, tb_[k], 32'd3, tw[k], 32'd0, 1'b0);
    end
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      send_rdy = 1'b0;
      recv_val = (idx < 4);
      if (idx < 4) set_in(ta[idx], ta[idx] + 32'd1, tb_[idx], 32'd3, tw[idx], 32'd0, 1'b0);
      #1;
      if (recv_val && recv_rdy) idx++;
    end
    nvec++;
    if (idx !== 2) begin nerr++; $display("FAIL bp_accepted got %0d want 2", idx); end
    nvec++;
    if (recv_rdy !== 1'b0) begin nerr++; $display("FAIL bp_recv_rdy got %b want 0", recv_rdy); end
    nvec++;
    if (send_val !== 1'b1 || {cR, cC, dR, dC} !== expv[0]) begin
      nerr++; $display("FAIL bp_frozen got %h val %b want %h", {cR, cC, dR, dC}, send_val, expv[0]);
    end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      send_rdy = 1'b1;
      recv_val = (idx < 4);
      if (idx < 4) set_in(ta[idx], ta[idx] + 32'd1, tb_[idx], 32'd3, tw[idx], 32'd0, 1'b0);
      #1;
      if (send_val) begin got.push_back({cR, cC, dR, dC}); cyc.push_back(c); end
      if (recv_val && recv_rdy) idx++;
    end
    recv_val = 1'b0;
    nvec++;
    if (got.size() !== 4) begin nerr++; $display("FAIL bp_count got %0d want 4", got.size()); end
    for (int k = 0; k < got.size() && k < 4; k++) begin
      nvec++;
      if (got[k] !== expv[k]) begin nerr++; $display("FAIL bp_order[%0d] got %h want %h", k, got[k], expv[k]); end
    end
    if (got.size() == 4) begin
      nvec++;
      if (cyc[3] - cyc[0] !== 3) begin nerr++; $display("FAIL bp_rate span got %0d want 3", cyc[3] - cyc[0]); end
    end
  endtask

  task automatic test_back_to_back;
    logic [127:0] expq[$];
    logic [127:0] got[$];
    int cyc[$];
    int sent = 0;
    logic [31:0] v[6];
    for (int c = 0; c < 120; c++) begin
      @(negedge clk);
      send_rdy = 1'b1;
      if (sent < 100) begin
        for (int j = 0; j < 6; j++) v[j] = $urandom;
        if (sent % 2 == 1) begin
          v[4] = $urandom_range(32'h0003_0000, 0) - 32'h0001_8000;
          v[5] = $urandom_range(32'h0003_0000, 0) - 32'h0001_8000;
        end
        if (sent == 0) begin
          v[0] = 32'd0; v[1] = 32'd0; v[2] = 32'hFFFF_FFFF; v[3] = 32'd0; v[4] = 32'h0000_8000; v[5] = 32'd0;
        end
        set_in(v[0], v[1], v[2], v[3], v[4], v[5], sent[2]);
        recv_val = 1'b1;
      end else begin
        recv_val = 1'b0;
      end
      #1;
      if (send_val) begin got.push_back({cR, cC, dR, dC}); cyc.push_back(c); end
      if (recv_val && recv_rdy) begin
        expq.push_back(model(aR, aC, bR, bC, wR, wC, scale));
        sent++;
      end
    end
    recv_val = 1'b0;
    nvec++;
    if (got.size() !== 100) begin nerr++; $display("FAIL b2b_count got %0d want 100", got.size()); end
    for (int k = 0; k < got.size() && k < expq.size(); k++) begin
      nvec++;
      if (got[k] !== expq[k]) begin nerr++; $display("FAIL b2b_data[%0d] got %h want %h", k, got[k], expq[k]); end
    end
    if (got.size() == 100) begin
      nvec++;
      if (cyc[99] - cyc[0] !== 99) begin nerr++; $display("FAIL b2b_rate span got %0d want 99", cyc[99] - cyc[0]); end
    end
  endtask

  task automatic test_reset_mid;
    int stale = 0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      send_rdy = 1'b0;
      recv_val = 1'b1;
      set_in(32'd50 + 32'(c), 32'd60, 32'd5, 32'd6, ONE, ONE, 1'b0);
    end
    @(negedge clk);
    recv_val = 1'b0;
    nvec++;
    if (send_val !== 1'b1 || recv_rdy !== 1'b0) begin
      nerr++; $display("FAIL rstmid_full got val %b rdy %b want 1 0", send_val, recv_rdy);
    end
    #2 reset = 1'b1;
    #1;
    nvec++;
    if (send_val !== 1'b0) begin nerr++; $display("FAIL rstmid_val got %b want 0", send_val); end
    nvec++;
    if ({cR, cC, dR, dC} !== 128'd0) begin nerr++; $display("FAIL rstmid_data got %h want 0", {cR, cC, dR, dC}); end
    @(negedge clk);
    #2 reset = 1'b0;
    send_rdy = 1'b1;
    #1;
    nvec++;
    if (recv_rdy !== 1'b1) begin nerr++; $display("FAIL rstmid_recv_rdy got %b want 1", recv_rdy); end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (send_val) stale++;
    end
    nvec++;
    if (stale !== 0) begin nerr++; $display("FAIL rstmid_stale got %0d outputs want 0", stale); end
  endtask

  initial begin
    test_reset();
    test_unity();
    test_twiddle_j();
    test_scale();
    test_trunc();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
